// File: rtl/red_pitaya_fads_sort_seq_pkg.sv
// Shared definitions for the FADS sort sequencer: register offsets,
// FSM state encoding and the default counter width.
package red_pitaya_fads_pkg;

    localparam int CW_DEFAULT = 24;

    localparam logic [19:0] ADDR_CTRL     = 20'h00000;
    localparam logic [19:0] ADDR_DELAY    = 20'h00004;
    localparam logic [19:0] ADDR_WIDTH    = 20'h00008;
    localparam logic [19:0] ADDR_HOLDOFF  = 20'h0000C;
    localparam logic [19:0] ADDR_FIRE_CNT = 20'h00010;
    localparam logic [19:0] ADDR_MISS_CNT = 20'h00014;
    localparam logic [19:0] ADDR_STATUS   = 20'h00018;
    localparam logic [19:0] ADDR_QUAL     = 20'h0001C;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DELAY   = 2'd1,
        ST_FIRE    = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_e;

endpackage

// File: rtl/red_pitaya_fads_sort_seq_if.sv
// Red Pitaya system-bus slice used to configure and observe the sort sequencer.
interface red_pitaya_fads_sort_seq_if;
    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic [3:0]  sys_sel;
    logic        sys_wen;
    logic        sys_ren;
    logic [31:0] sys_rdata;
    logic        sys_err;
    logic        sys_ack;

    modport master (
        output sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
        input  sys_rdata, sys_err, sys_ack
    );

    modport slave (
        input  sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
        output sys_rdata, sys_err, sys_ack
    );
endinterface

// File: rtl/red_pitaya_fads_qual.sv
// Droplet-detect qualifier: emits one event once the level has been high for
// qual_i+1 consecutive samples after having been seen low.
module red_pitaya_fads_qual
    import red_pitaya_fads_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       level_i,
    input  logic [7:0] qual_i,
    output logic       evt_o
);

    logic [8:0] cnt_q, cnt_d;
    logic       seen_low_q, seen_low_d;
    logic       fired_q, fired_d;

    // A level that is high from reset onward never qualifies until it drops.
    always_comb begin
        evt_o      = level_i && seen_low_q && !fired_q && (cnt_q == {1'b0, qual_i});
        seen_low_d = seen_low_q || !level_i;
        fired_d    = level_i && (fired_q || evt_o);
        cnt_d      = 9'd0;
        if (level_i) begin
            cnt_d = (cnt_q == 9'h1FF) ? cnt_q : cnt_q + 9'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= 9'd0;
            seen_low_q <= 1'b0;
            fired_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            seen_low_q <= seen_low_d;
            fired_q    <= fired_d;
        end
    end

endmodule

// File: rtl/red_pitaya_fads_sort_seq.sv
// FADS sort sequencer: droplet trigger -> delay -> ASG pulse -> holdoff.
// Optional trigger qualifier (QUAL register at 0x1C) enabled by FADS_SORT_QUAL_EN.
module red_pitaya_fads_sort_seq
    import red_pitaya_fads_pkg::*;
#(
    parameter int CW = CW_DEFAULT
)(
    input  logic                       adc_clk_i,
    input  logic                       adc_rstn_i,
    input  logic                       sort_trig_i,
    output logic                       asg_trig_o,
    output logic                       busy_o,
    red_pitaya_fads_sort_seq_if.slave  sys
);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] delay_q, delay_d, width_q, width_d, holdoff_q, holdoff_d;
    logic [31:0]   fire_cnt_q, fire_cnt_d, miss_cnt_q, miss_cnt_d, rdata_q, rdata_d;
    logic          en_q, en_d, asg_q, asg_d, ack_q, ack_d, evt_q, evt_d;
    logic          trig_q, v1_q, trig_evt, fire_entry, miss, ctrl_wr, sw_trig;
    logic [19:0]   addr;
    logic          unused_bits;

    assign addr        = sys.sys_addr[19:0];
    assign unused_bits = ^{sys.sys_sel, sys.sys_addr[31:20], sys.sys_wdata};
    assign ctrl_wr     = sys.sys_wen && (addr == ADDR_CTRL);
    assign en_d        = ctrl_wr ? sys.sys_wdata[0] : en_q;
    assign sw_trig     = ctrl_wr && sys.sys_wdata[1];
    assign evt_d       = trig_evt || sw_trig;

    assign asg_trig_o    = asg_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign sys.sys_rdata = rdata_q;
    assign sys.sys_ack   = ack_q;
    assign sys.sys_err   = 1'b0;

`ifdef FADS_SORT_QUAL_EN
    logic [7:0] qual_q, qual_d;

    // Before the first sample the level is forced high so a held input cannot qualify.
    red_pitaya_fads_qual u_qual (
        .clk     (adc_clk_i),
        .rst_n   (adc_rstn_i),
        .level_i (trig_q || !v1_q),
        .qual_i  (qual_q),
        .evt_o   (trig_evt)
    );
`else
    logic prev_q, v2_q;

    // v2_q masks the edge until prev_q holds a genuine post-reset sample.
    assign trig_evt = trig_q && !prev_q && v2_q;

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            prev_q <= 1'b0;
            v2_q   <= 1'b0;
        end else begin
            prev_q <= trig_q;
            v2_q   <= v1_q;
        end
    end
`endif

    always_comb begin
        delay_d    = delay_q;
        width_d    = width_q;
        holdoff_d  = holdoff_q;
        fire_cnt_d = fire_entry ? fire_cnt_q + 32'd1 : fire_cnt_q;
        miss_cnt_d = miss ? miss_cnt_q + 32'd1 : miss_cnt_q;
        rdata_d    = rdata_q;
        ack_d      = sys.sys_wen || sys.sys_ren;
`ifdef FADS_SORT_QUAL_EN
        qual_d     = qual_q;
`endif
        if (sys.sys_wen) begin
            case (addr)
                ADDR_DELAY:    delay_d    = sys.sys_wdata[CW-1:0];
                ADDR_WIDTH:    width_d    = sys.sys_wdata[CW-1:0];
                ADDR_HOLDOFF:  holdoff_d  = sys.sys_wdata[CW-1:0];
                ADDR_FIRE_CNT: fire_cnt_d = 32'd0;
                ADDR_MISS_CNT: miss_cnt_d = 32'd0;
`ifdef FADS_SORT_QUAL_EN
                ADDR_QUAL:     qual_d     = sys.sys_wdata[7:0];
`endif
                default: ;
            endcase
        end
        if (sys.sys_ren) begin
            case (addr)
                ADDR_CTRL:     rdata_d = {31'd0, en_q};
                ADDR_DELAY:    rdata_d = 32'(delay_q);
                ADDR_WIDTH:    rdata_d = 32'(width_q);
                ADDR_HOLDOFF:  rdata_d = 32'(holdoff_q);
                ADDR_FIRE_CNT: rdata_d = fire_cnt_q;
                ADDR_MISS_CNT: rdata_d = miss_cnt_q;
                ADDR_STATUS:   rdata_d = {29'd0, asg_q, state_q};
`ifdef FADS_SORT_QUAL_EN
                ADDR_QUAL:     rdata_d = {24'd0, qual_q};
`endif
                default:       rdata_d = 32'd0;
            endcase
        end
    end

    // Each phase loads its counter on entry; clearing EN aborts to IDLE without counting.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fire_entry = 1'b0;
        miss       = evt_q && (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (evt_q && en_d) begin
                    state_d = ST_DELAY;
                    cnt_d   = delay_q;
                end
            end
            ST_DELAY: begin
                if (cnt_q == '0) begin
                    state_d    = ST_FIRE;
                    cnt_d      = (width_q == '0) ? CW'(1) : width_q;
                    fire_entry = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_FIRE: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = ST_HOLDOFF;
                    cnt_d   = holdoff_q;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if ((state_q != ST_IDLE) && !en_d) begin
            state_d    = ST_IDLE;
            fire_entry = 1'b0;
        end
        asg_d = (state_d == ST_FIRE);
    end

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            delay_q    <= '0;
            width_q    <= '0;
            holdoff_q  <= '0;
            fire_cnt_q <= 32'd0;
            miss_cnt_q <= 32'd0;
            rdata_q    <= 32'd0;
            en_q       <= 1'b0;
            asg_q      <= 1'b0;
            ack_q      <= 1'b0;
            evt_q      <= 1'b0;
            trig_q     <= 1'b0;
            v1_q       <= 1'b0;
`ifdef FADS_SORT_QUAL_EN
            qual_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            delay_q    <= delay_d;
            width_q    <= width_d;
            holdoff_q  <= holdoff_d;
            fire_cnt_q <= fire_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            rdata_q    <= rdata_d;
            en_q       <= en_d;
            asg_q      <= asg_d;
            ack_q      <= ack_d;
            evt_q      <= evt_d;
            trig_q     <= sort_trig_i;
            v1_q       <= 1'b1;
`ifdef FADS_SORT_QUAL_EN
            qual_q     <= qual_d;
`endif
        end
    end

endmodule

// File: tb/tb_red_pitaya_fads_sort_seq.sv
// Directed self-checking bench for red_pitaya_fads_sort_seq (CW=24); the
// qualifier scenario runs only when FADS_SORT_QUAL_EN is defined.
module tb_red_pitaya_fads_sort_seq;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        sort_trig = 1'b0;
    logic        asg_trig;
    logic        busy;
    logic [31:0] rd;
    int          total = 0;
    int          bad = 0;

    red_pitaya_fads_sort_seq_if sys_bus ();

    red_pitaya_fads_sort_seq #(.CW(24)) dut (
        .adc_clk_i   (clk),
        .adc_rstn_i  (rstn),
        .sort_trig_i (sort_trig),
        .asg_trig_o  (asg_trig),
        .busy_o      (busy),
        .sys         (sys_bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        sys_bus.sys_addr  = a;
        sys_bus.sys_wdata = d;
        sys_bus.sys_wen   = 1'b1;
        tick();
        sys_bus.sys_wen   = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        sys_bus.sys_addr = a;
        sys_bus.sys_ren  = 1'b1;
        tick();
        sys_bus.sys_ren  = 1'b0;
        d = sys_bus.sys_rdata;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 300) begin
            tick();
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s_idle_timeout busy=%b required=0", tag, busy);
        end
    endtask

    task automatic test_reset();
        logic [31:0] addrs [7];
        addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18};
        tick();
        tick();
        total++;
        if ({asg_trig, busy, sys_bus.sys_ack, sys_bus.sys_err} !== 4'b0000 || sys_bus.sys_rdata !== 32'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got=%b rdata=%h required=0000/0",
                     {asg_trig, busy, sys_bus.sys_ack, sys_bus.sys_err}, sys_bus.sys_rdata);
        end
        rstn = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            bus_read(addrs[i], rd);
            total++;
            if (rd !== 32'd0) begin
                bad++;
                $display("[TB] FAIL reset_reg addr=%h got=%h required=0", addrs[i], rd);
            end
        end
    endtask

    task automatic test_bus();
        bus_write(32'h04, 32'hFFFF_FFFF);
        total++;
        if (sys_bus.sys_ack !== 1'b1) begin
            bad++;
            $display("[TB] FAIL bus_write_ack got=%b required=1", sys_bus.sys_ack);
        end
        tick();
        total++;
        if (sys_bus.sys_ack !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bus_ack_drop got=%b required=0", sys_bus.sys_ack);
        end
        bus_read(32'h8000_0004, rd);
        total++;
        if (rd !== 32'h00FF_FFFF) begin
            bad++;
            $display("[TB] FAIL bus_delay_trunc got=%h required=00ffffff", rd);
        end
        bus_write(32'h40, 32'h1234_5678);
        total++;
        if (sys_bus.sys_ack !== 1'b1) begin
            bad++;
            $display("[TB] FAIL bus_unmapped_ack got=%b required=1", sys_bus.sys_ack);
        end
        bus_read(32'h40, rd);
        total++;
        if (rd !== 32'd0 || sys_bus.sys_ack !== 1'b1) begin
            bad++;
            $display("[TB] FAIL bus_unmapped_read got=%h ack=%b required=0 ack=1", rd, sys_bus.sys_ack);
        end
        bus_write(32'h1C, 32'h0000_01A5);
        bus_read(32'h1C, rd);
        total++;
`ifdef FADS_SORT_QUAL_EN
        if (rd !== 32'h0000_00A5) begin
            bad++;
            $display("[TB] FAIL bus_qual_reg got=%h required=000000a5", rd);
        end
        bus_write(32'h1C, 32'h0);
`else
        if (rd !== 32'd0) begin
            bad++;
            $display("[TB] FAIL bus_qual_unmapped got=%h required=0", rd);
        end
`endif
    endtask

    task automatic test_basic();
        logic exp_asg, exp_busy;
        bus_write(32'h04, 32'd10);
        bus_write(32'h08, 32'd5);
        bus_write(32'h0C, 32'd20);
        bus_write(32'h00, 32'd1);
        tick();
        sort_trig = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (k == 20) sort_trig = 1'b0;
            exp_asg  = (k >= 13 && k < 18);
            exp_busy = (k >= 2 && k <= 38);
            total++;
            if (asg_trig !== exp_asg || busy !== exp_busy) begin
                bad++;
                $display("[TB] FAIL basic_seq edge=%0d asg=%b busy=%b required asg=%b busy=%b",
                         k, asg_trig, busy, exp_asg, exp_busy);
            end
        end
        bus_read(32'h10, rd);
        total++;
        if (rd !== 32'd1) begin
            bad++;
            $display("[TB] FAIL basic_fire_cnt got=%0d required=1", rd);
        end
    endtask

    task automatic test_miss();
        logic exp_asg;
        bus_write(32'h10, 32'd0);
        bus_write(32'h14, 32'd0);
        tick();
        sort_trig = 1'b1;
        for (int k = 0; k < 61; k++) begin
            tick();
            if (k == 3 || k == 10 || k == 45) sort_trig = 1'b0;
            if (k == 7 || k == 39) sort_trig = 1'b1;
            exp_asg = (k >= 13 && k < 18) || (k >= 53 && k < 58);
            total++;
            if (asg_trig !== exp_asg) begin
                bad++;
                $display("[TB] FAIL miss_seq edge=%0d asg=%b required=%b", k, asg_trig, exp_asg);
            end
        end
        wait_idle("miss");
        bus_read(32'h14, rd);
        total++;
        if (rd !== 32'd1) begin
            bad++;
            $display("[TB] FAIL miss_cnt got=%0d required=1", rd);
        end
        bus_read(32'h10, rd);
        total++;
        if (rd !== 32'd2) begin
            bad++;
            $display("[TB] FAIL miss_fire_cnt got=%0d required=2", rd);
        end
    endtask

    task automatic test_min();
        logic exp_asg, exp_busy;
        bus_write(32'h04, 32'd0);
        bus_write(32'h08, 32'd0);
        bus_write(32'h0C, 32'd0);
        tick();
        sort_trig = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_asg  = (k == 3);
            exp_busy = (k >= 2 && k <= 4);
            total++;
            if (asg_trig !== exp_asg || busy !== exp_busy) begin
                bad++;
                $display("[TB] FAIL min_seq edge=%0d asg=%b busy=%b required asg=%b busy=%b",
                         k, asg_trig, busy, exp_asg, exp_busy);
            end
        end
        sort_trig = 1'b0;
        tick();
    endtask

    task automatic test_swtrig();
        logic exp_asg;
        bus_write(32'h04, 32'd2);
        bus_write(32'h08, 32'd1);
        bus_write(32'h00, 32'd3);
        for (int k = 1; k < 9; k++) begin
            tick();
            exp_asg = (k == 4);
            total++;
            if (asg_trig !== exp_asg) begin
                bad++;
                $display("[TB] FAIL swtrig_seq edge=%0d asg=%b required=%b", k, asg_trig, exp_asg);
            end
        end
        bus_read(32'h00, rd);
        total++;
        if (rd !== 32'd1) begin
            bad++;
            $display("[TB] FAIL swtrig_ctrl_read got=%h required=1", rd);
        end
    endtask

    task automatic test_abort();
        bus_write(32'h04, 32'd10);
        bus_write(32'h08, 32'd100);
        bus_write(32'h0C, 32'd20);
        bus_write(32'h10, 32'd0);
        tick();
        sort_trig = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (k == 13) begin
                total++;
                if (asg_trig !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL abort_fire_start asg=%b required=1", asg_trig);
                end
            end
        end
        bus_write(32'h00, 32'd0);
        total++;
        if (asg_trig !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort_stop asg=%b busy=%b required 0/0", asg_trig, busy);
        end
        bus_read(32'h18, rd);
        total++;
        if (rd !== 32'd0) begin
            bad++;
            $display("[TB] FAIL abort_status got=%h required=0", rd);
        end
        sort_trig = 1'b0;
        tick();
        tick();
        sort_trig = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL disabled_event busy=%b required=0", busy);
        end
        bus_read(32'h14, rd);
        total++;
        if (rd !== 32'd1) begin
            bad++;
            $display("[TB] FAIL disabled_miss_cnt got=%0d required=1", rd);
        end
        bus_read(32'h10, rd);
        total++;
        if (rd !== 32'd1) begin
            bad++;
            $display("[TB] FAIL abort_fire_cnt got=%0d required=1", rd);
        end
        sort_trig = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic exp_asg;
        bus_write(32'h04, 32'd10);
        bus_write(32'h08, 32'd5);
        bus_write(32'h0C, 32'd0);
        bus_write(32'h00, 32'd1);
        tick();
        sort_trig = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rstmid_busy_before got=%b required=1", busy);
        end
        rstn = 1'b0;
        #1;
        total++;
        if ({asg_trig, busy, sys_bus.sys_ack, sys_bus.sys_err} !== 4'b0000 || sys_bus.sys_rdata !== 32'd0) begin
            bad++;
            $display("[TB] FAIL rstmid_outputs got=%b rdata=%h required=0000/0",
                     {asg_trig, busy, sys_bus.sys_ack, sys_bus.sys_err}, sys_bus.sys_rdata);
        end
        tick();
        tick();
        rstn = 1'b1;
        bus_write(32'h00, 32'd1);
        for (int k = 0; k < 12; k++) begin
            tick();
            total++;
            if (busy !== 1'b0 || asg_trig !== 1'b0) begin
                bad++;
                $display("[TB] FAIL rstmid_held_high k=%0d busy=%b asg=%b required 0/0", k, busy, asg_trig);
            end
        end
        bus_write(32'h04, 32'd10);
        bus_write(32'h08, 32'd5);
        sort_trig = 1'b0;
        tick();
        tick();
        sort_trig = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            exp_asg = (k >= 13 && k < 18);
            total++;
            if (asg_trig !== exp_asg) begin
                bad++;
                $display("[TB] FAIL rstmid_retrigger edge=%0d asg=%b required=%b", k, asg_trig, exp_asg);
            end
        end
        sort_trig = 1'b0;
        wait_idle("rstmid");
    endtask

`ifdef FADS_SORT_QUAL_EN
    task automatic test_qual();
        logic exp_asg;
        bus_write(32'h1C, 32'd3);
        bus_write(32'h04, 32'd4);
        bus_write(32'h08, 32'd2);
        bus_write(32'h0C, 32'd0);
        tick();
        sort_trig = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (k == 2) sort_trig = 1'b0;
            total++;
            if (asg_trig !== 1'b0) begin
                bad++;
                $display("[TB] FAIL qual_glitch edge=%0d asg=%b required=0", k, asg_trig);
            end
        end
        sort_trig = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (k == 3) sort_trig = 1'b0;
            exp_asg = (k == 10 || k == 11);
            total++;
            if (asg_trig !== exp_asg) begin
                bad++;
                $display("[TB] FAIL qual_pass edge=%0d asg=%b required=%b", k, asg_trig, exp_asg);
            end
        end
    endtask
`endif

    initial begin
        sys_bus.sys_addr  = 32'd0;
        sys_bus.sys_wdata = 32'd0;
        sys_bus.sys_sel   = 4'hF;
        sys_bus.sys_wen   = 1'b0;
        sys_bus.sys_ren   = 1'b0;
        test_reset();
        test_bus();
        test_basic();
        test_miss();
        test_min();
        test_swtrig();
        test_abort();
        test_reset_mid();
`ifdef FADS_SORT_QUAL_EN
        test_qual();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/red_pitaya_fads_sort_seq.md
RED_PITAYA_FADS_SORT_SEQ -- requirements
Module: red_pitaya_fads_sort_seq

Interface
REQ-001 Parameter CW, default 24: width of delay/width/holdoff counters and registers.
REQ-002 adc_clk_i  in  1  sole clock; all logic on rising edge.
REQ-003 adc_rstn_i  in  1  reset, asynchronous, active-low.
REQ-004 sort_trig_i  in  1  droplet-detect level from the FADS threshold comparator, synchronous to adc_clk_i.
REQ-005 asg_trig_o  out  1  sort pulse to the ASG external-trigger input.
REQ-006 busy_o  out  1  high whenever the FSM is not in IDLE.
REQ-007 sys_addr  in  32  bus address; decode on bits [19:0].
REQ-008 sys_wdata  in  32  bus write data.
REQ-009 sys_sel  in  4  byte select; ignored, writes are full-word.
REQ-010 sys_wen / sys_ren  in  1 each  single-cycle write/read strobes.
REQ-011 sys_rdata  out  32  read data; sys_err  out  1  always 0; sys_ack  out  1  acknowledge.

Function
REQ-012 Register map: 0x00 CTRL (bit0 EN rw, bit1 SWTRIG write-1 self-clearing, reads 0); 0x04 DELAY[CW-1:0]; 0x08 WIDTH[CW-1:0]; 0x0C HOLDOFF[CW-1:0]; 0x10 FIRE_CNT 32b RO; 0x14 MISS_CNT 32b RO; 0x18 STATUS RO (bits[1:0] state, bit2 asg_trig_o).
REQ-013 sys_ack asserts one cycle after any sys_wen or sys_ren, mapped or not; unmapped reads return 0; unmapped writes have no effect.
REQ-014 sort_trig_i is registered once; trigger event = registered value 1 while previous registered value 0 (rising edge), or a SWTRIG write.
REQ-015 FSM states IDLE(0), DELAY(1), FIRE(2), HOLDOFF(3).
REQ-016 IDLE: trigger event with EN=1 -> DELAY with counter loaded from DELAY; EN=0 events are ignored, not counted.
REQ-017 DELAY: counter decrements each cycle; -> FIRE on the cycle the counter reads 0 (DELAY=0 passes through DELAY for one cycle).
REQ-018 Latency: asg_trig_o rises exactly DELAY+3 edges after the edge on which sort_trig_i is first sampled high.
REQ-019 FIRE: asg_trig_o registered high for exactly max(WIDTH,1) cycles; FIRE_CNT increments once on FIRE entry; then -> HOLDOFF.
REQ-020 HOLDOFF: asg_trig_o low for HOLDOFF cycles (0 means direct return), then -> IDLE.
REQ-021 Each counter samples its register on state entry; writes during a state take effect at the next entry.
REQ-022 Trigger events arriving in any non-IDLE state are dropped and increment MISS_CNT; the event on the cycle of return to IDLE is accepted.
REQ-023 EN written 0 mid-operation: FSM -> IDLE on the next edge, asg_trig_o low that same edge, counters unchanged.
REQ-024 FIRE_CNT and MISS_CNT wrap 0xFFFFFFFF -> 0; writing 0x10 or 0x14 clears the respective counter.

Reset
REQ-025 While adc_rstn_i=0: state IDLE, asg_trig_o=0, busy_o=0, sys_ack=0, sys_err=0, sys_rdata=0, all registers and counters 0, edge-detect history 0.
REQ-026 A sort_trig_i already high at reset release does not produce a trigger event until it falls and rises again.

Configuration
REQ-027 Macro FADS_SORT_QUAL_EN: when defined, register 0x1C QUAL[7:0] is added, and a rising edge becomes a trigger event only after sort_trig_i stays high for QUAL+1 consecutive samples (QUAL=0 equals plain edge, latency +QUAL); when undefined, 0x1C is unmapped and REQ-014 applies unchanged.

Structure
REQ-028 Package red_pitaya_fads_pkg holds register offsets, state encoding, and CW default.
REQ-029 The qualifier is sub-module red_pitaya_fads_qual (clock, reset, level in, QUAL in, event out), instantiated only under FADS_SORT_QUAL_EN.

Verification
REQ-030 EN=1, DELAY=10, WIDTH=5, HOLDOFF=20; sort_trig_i 0->1 -> asg_trig_o high 13 edges later for 5 cycles; FIRE_CNT=1.
REQ-031 Same config, second edge 8 cycles after the first -> no second pulse, MISS_CNT=1; edge 40 cycles after the first -> second pulse.
REQ-032 DELAY=0, WIDTH=0, HOLDOFF=0 -> 1-cycle pulse 3 edges after the edge, FSM back to IDLE 2 cycles later.
REQ-033 EN cleared at the 2nd FIRE cycle with WIDTH=100 -> asg_trig_o low next edge, STATUS reads 0.
REQ-034 adc_rstn_i asserted mid-DELAY while sort_trig_i held high -> all outputs 0 immediately; after release, no pulse until sort_trig_i toggles.
REQ-035 FADS_SORT_QUAL_EN defined, QUAL=3: 3-cycle high glitch -> no pulse; 4-cycle high -> pulse at DELAY+6 edges.
